// File: rtl/rs_station_if.sv
// Dispatch, wakeup and issue signals of the reservation station, grouped as one bundle.
// The master side drives dispatch/broadcast/control; the slave side is the station.
interface rs_station_if #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int OP_W  = 6,
    parameter int CDB_N = 3
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic                     rdy;
    logic                     flush;
    logic                     disp_valid;
    logic                     disp_ready;
    logic [OP_W-1:0]          disp_op;
    logic [XLEN-1:0]          disp_pc;
    logic [XLEN-1:0]          disp_imm;
    logic [TAG_W-1:0]         disp_tag;
    logic [XLEN-1:0]          disp_vj;
    logic [XLEN-1:0]          disp_vk;
    logic                     disp_qj_valid;
    logic                     disp_qk_valid;
    logic [TAG_W-1:0]         disp_qj;
    logic [TAG_W-1:0]         disp_qk;
    logic [CDB_N-1:0]         cdb_valid;
    logic [CDB_N*TAG_W-1:0]   cdb_tag;
    logic [CDB_N*XLEN-1:0]    cdb_value;
    logic                     iss_valid;
    logic                     iss_ready;
    logic [OP_W-1:0]          iss_op;
    logic [XLEN-1:0]          iss_pc;
    logic [XLEN-1:0]          iss_imm;
    logic [TAG_W-1:0]         iss_tag;
    logic [XLEN-1:0]          iss_vj;
    logic [XLEN-1:0]          iss_vk;
    logic [CNT_W-1:0]         count;
    logic                     full;
    logic                     empty;

    modport master (
        output rdy, flush, disp_valid, disp_op, disp_pc, disp_imm, disp_tag,
               disp_vj, disp_vk, disp_qj_valid, disp_qk_valid, disp_qj, disp_qk,
               cdb_valid, cdb_tag, cdb_value, iss_ready,
        input  disp_ready, iss_valid, iss_op, iss_pc, iss_imm, iss_tag,
               iss_vj, iss_vk, count, full, empty
    );

    modport slave (
        input  rdy, flush, disp_valid, disp_op, disp_pc, disp_imm, disp_tag,
               disp_vj, disp_vk, disp_qj_valid, disp_qk_valid, disp_qj, disp_qk,
               cdb_valid, cdb_tag, cdb_value, iss_ready,
        output disp_ready, iss_valid, iss_op, iss_pc, iss_imm, iss_tag,
               iss_vj, iss_vk, count, full, empty
    );
endinterface

// File: rtl/rs_station.sv
// Out-of-order reservation station: captures operands from CDB broadcasts and
// issues the oldest ready entry to one execute unit, using an age matrix.
module rs_station #(
    parameter int DEPTH = 16,
    parameter int XLEN  = 32,
    parameter int TAG_W = 5,
    parameter int OP_W  = 6,
    parameter int CDB_N = 3
) (
    input  logic        clk,
    input  logic        rst,
    rs_station_if.slave io
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    // Returns {hit, value}; the lowest matching channel wins.
    function automatic logic [XLEN:0] cdb_match(
        input logic [TAG_W-1:0]       t,
        input logic [CDB_N-1:0]       v,
        input logic [CDB_N*TAG_W-1:0] tags,
        input logic [CDB_N*XLEN-1:0]  vals
    );
        logic [XLEN:0] r;
        r = '0;
        for (int c = CDB_N - 1; c >= 0; c--) begin
            if (v[c] && tags[c*TAG_W +: TAG_W] == t) r = {1'b1, vals[c*XLEN +: XLEN]};
        end
        return r;
    endfunction

    logic [DEPTH-1:0] valid_q, valid_d, qjv_q, qjv_d, qkv_q, qkv_d;
    logic [DEPTH-1:0] older_q [DEPTH];
    logic [DEPTH-1:0] older_d [DEPTH];
    logic [CNT_W-1:0] count_q, count_d;

    logic [OP_W-1:0]  op_q  [DEPTH];
    logic [XLEN-1:0]  pc_q  [DEPTH];
    logic [XLEN-1:0]  imm_q [DEPTH];
    logic [TAG_W-1:0] tag_q [DEPTH];
    logic [TAG_W-1:0] qj_q  [DEPTH];
    logic [TAG_W-1:0] qk_q  [DEPTH];
    logic [XLEN-1:0]  vj_q  [DEPTH];
    logic [XLEN-1:0]  vk_q  [DEPTH];

    logic [DEPTH-1:0] wj_hit, wk_hit, wake_j, wake_k, cand;
    logic [XLEN-1:0]  wj_val [DEPTH];
    logic [XLEN-1:0]  wk_val [DEPTH];
    logic             bj_hit, bk_hit;
    logic [XLEN-1:0]  bj_val, bk_val;
    logic [IDX_W-1:0] free_idx, sel_idx;
    logic             any_cand, blocked, adv, full, disp_fire, iss_fire;

    assign adv        = io.rdy & ~io.flush;
    assign full       = (count_q == CNT_W'(DEPTH));
    assign disp_fire  = io.disp_valid & io.disp_ready;
    assign iss_fire   = io.iss_valid & io.iss_ready;

    always_comb begin
        {bj_hit, bj_val} = cdb_match(io.disp_qj, io.cdb_valid, io.cdb_tag, io.cdb_value);
        {bk_hit, bk_val} = cdb_match(io.disp_qk, io.cdb_valid, io.cdb_tag, io.cdb_value);
        for (int i = 0; i < DEPTH; i++) begin
            {wj_hit[i], wj_val[i]} = cdb_match(qj_q[i], io.cdb_valid, io.cdb_tag, io.cdb_value);
            {wk_hit[i], wk_val[i]} = cdb_match(qk_q[i], io.cdb_valid, io.cdb_tag, io.cdb_value);
        end
    end

    assign wake_j = valid_q & qjv_q & wj_hit;
    assign wake_k = valid_q & qkv_q & wk_hit;
    assign cand   = valid_q & ~qjv_q & ~qkv_q;

    always_comb begin
        free_idx = '0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) free_idx = IDX_W'(i);
        end
    end

    // An entry is selected when no other candidate is marked older than it.
    always_comb begin
        sel_idx  = '0;
        any_cand = 1'b0;
        blocked  = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (cand[j] && older_q[j][i]) blocked = 1'b1;
            end
            if (cand[i] && !blocked) begin
                sel_idx  = IDX_W'(i);
                any_cand = 1'b1;
            end
        end
    end

    assign io.disp_ready = adv & ~full;
    assign io.iss_valid  = adv & any_cand;
    assign io.iss_op     = io.iss_valid ? op_q[sel_idx]  : '0;
    assign io.iss_pc     = io.iss_valid ? pc_q[sel_idx]  : '0;
    assign io.iss_imm    = io.iss_valid ? imm_q[sel_idx] : '0;
    assign io.iss_tag    = io.iss_valid ? tag_q[sel_idx] : '0;
    assign io.iss_vj     = io.iss_valid ? vj_q[sel_idx]  : '0;
    assign io.iss_vk     = io.iss_valid ? vk_q[sel_idx]  : '0;
    assign io.count      = count_q;
    assign io.full       = full;
    assign io.empty      = (count_q == '0);

    always_comb begin
        valid_d = valid_q;
        qjv_d   = qjv_q;
        qkv_d   = qkv_q;
        older_d = older_q;
        count_d = count_q;
        if (io.flush) begin
            valid_d = '0;
            qjv_d   = '0;
            qkv_d   = '0;
            count_d = '0;
        end else begin
            qjv_d = qjv_q & ~wake_j;
            qkv_d = qkv_q & ~wake_k;
            if (iss_fire) valid_d[sel_idx] = 1'b0;
            if (disp_fire) begin
                valid_d[free_idx] = 1'b1;
                qjv_d[free_idx]   = io.disp_qj_valid & ~bj_hit;
                qkv_d[free_idx]   = io.disp_qk_valid & ~bk_hit;
                // Newcomer is younger than every other slot.
                for (int j = 0; j < DEPTH; j++) begin
                    older_d[free_idx][j] = 1'b0;
                    older_d[j][free_idx] = (j != int'(free_idx));
                end
            end
            count_d = count_q + CNT_W'(disp_fire) - CNT_W'(iss_fire);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            qjv_q   <= '0;
            qkv_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) older_q[i] <= '0;
        end else if (io.rdy) begin
            valid_q <= valid_d;
            qjv_q   <= qjv_d;
            qkv_q   <= qkv_d;
            count_q <= count_d;
            older_q <= older_d;
        end
    end

    always_ff @(posedge clk) begin
        if (adv) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (disp_fire && free_idx == IDX_W'(i)) begin
                    op_q[i]  <= io.disp_op;
                    pc_q[i]  <= io.disp_pc;
                    imm_q[i] <= io.disp_imm;
                    tag_q[i] <= io.disp_tag;
                    qj_q[i]  <= io.disp_qj;
                    qk_q[i]  <= io.disp_qk;
                    vj_q[i]  <= (io.disp_qj_valid && bj_hit) ? bj_val : io.disp_vj;
                    vk_q[i]  <= (io.disp_qk_valid && bk_hit) ? bk_val : io.disp_vk;
                end else begin
                    if (wake_j[i]) vj_q[i] <= wj_val[i];
                    if (wake_k[i]) vk_q[i] <= wk_val[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_rs_station.sv
// Directed bench for rs_station: a vector table for the basic dispatch/wakeup/issue
// flows plus hand sequences for fill, out-of-order slot reuse, flush and rdy stall.
module tb_rs_station;
    localparam int DEPTH = 16;
    localparam int XLEN  = 32;
    localparam int TAG_W = 5;
    localparam int OP_W  = 6;
    localparam int CDB_N = 3;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    rs_station_if #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .CDB_N(CDB_N)) bus ();

    rs_station #(.DEPTH(DEPTH), .XLEN(XLEN), .TAG_W(TAG_W), .OP_W(OP_W), .CDB_N(CDB_N)) dut (
        .clk (clk),
        .rst (rst),
        .io  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        dv;
        logic [4:0]  dtag;
        logic        qjv;
        logic [4:0]  qj;
        logic        qkv;
        logic [4:0]  qk;
        logic [31:0] vj;
        logic [31:0] vk;
        logic [2:0]  cv;
        logic [14:0] ct;
        logic [95:0] cval;
        logic        ir;
        logic        e_iv;
        logic [4:0]  e_tag;
        logic [31:0] e_vj;
        logic [31:0] e_vk;
        logic [4:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic dv, input logic [4:0] dtag, input logic qjv, input logic [4:0] qj,
                       input logic qkv, input logic [4:0] qk, input logic [31:0] vj, input logic [31:0] vk,
                       input logic [2:0] cv, input logic [14:0] ct, input logic [95:0] cval, input logic ir,
                       input logic e_iv, input logic [4:0] e_tag, input logic [31:0] e_vj,
                       input logic [31:0] e_vk, input logic [4:0] e_cnt);
        vec_t v;
        v.dv = dv; v.dtag = dtag; v.qjv = qjv; v.qj = qj; v.qkv = qkv; v.qk = qk;
        v.vj = vj; v.vk = vk; v.cv = cv; v.ct = ct; v.cval = cval; v.ir = ir;
        v.e_iv = e_iv; v.e_tag = e_tag; v.e_vj = e_vj; v.e_vk = e_vk; v.e_cnt = e_cnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic idle();
        bus.rdy = 1'b1; bus.flush = 1'b0; bus.disp_valid = 1'b0;
        bus.disp_op = '0; bus.disp_pc = '0; bus.disp_imm = '0; bus.disp_tag = '0;
        bus.disp_vj = '0; bus.disp_vk = '0; bus.disp_qj_valid = 1'b0; bus.disp_qk_valid = 1'b0;
        bus.disp_qj = '0; bus.disp_qk = '0; bus.cdb_valid = '0; bus.cdb_tag = '0;
        bus.cdb_value = '0; bus.iss_ready = 1'b0;
    endtask

    task automatic disp(input logic [4:0] tag, input logic qjv, input logic [4:0] qj,
                        input logic [31:0] vj, input logic [31:0] vk);
        bus.disp_valid = 1'b1; bus.disp_tag = tag;
        bus.disp_op = OP_W'(tag) + 6'd1; bus.disp_pc = 32'h1000 + 32'(tag) * 4;
        bus.disp_imm = 32'(tag) * 7;
        bus.disp_qj_valid = qjv; bus.disp_qj = qj; bus.disp_vj = vj; bus.disp_vk = vk;
    endtask

    task automatic bcast(input int ch, input logic [4:0] tag, input logic [31:0] val);
        bus.cdb_valid[ch] = 1'b1;
        bus.cdb_tag[ch*TAG_W +: TAG_W] = tag;
        bus.cdb_value[ch*XLEN +: XLEN] = val;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst.empty", bus.empty, 1);
        chk("rst.full", bus.full, 0);
        chk("rst.disp_ready", bus.disp_ready, 1);
        chk("rst.iss_valid", bus.iss_valid, 0);
        chk("rst.iss_tag", bus.iss_tag, 0);
        chk("rst.iss_vj", bus.iss_vj, 0);
        chk("rst.count", bus.count, 0);
        rst = 1'b0;

        // single ready entry
        add(1, 3, 0, 0, 0, 0, 5, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 5, 7, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // wakeup on channel 1 two cycles after dispatch
        add(1, 4, 1, 9, 0, 0, 0, 32'h11, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b010, {5'd0, 5'd9, 5'd0}, {32'd0, 32'h1234, 32'd0}, 1, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 4, 32'h1234, 32'h11, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // dispatch-time bypass on k
        add(1, 6, 0, 0, 1, 2, 32'h22, 0, 3'b001, {10'd0, 5'd2}, {64'd0, 32'hAA}, 1, 0, 0, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6, 32'h22, 32'hAA, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        // oldest-first: wake 12 and 10 together, 11 stays
        add(1, 10, 1, 20, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        add(1, 11, 1, 21, 0, 0, 0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        add(1, 12, 1, 22, 0, 0, 0, 3, 0, 0, 0, 0, 0, 0, 0, 0, 2);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b101, {5'd20, 5'd0, 5'd22}, {32'h10A, 32'd0, 32'h12C}, 0, 0, 0, 0, 0, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 10, 32'h10A, 1, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 10, 32'h10A, 1, 3);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 12, 32'h12C, 3, 2);
        // unmatched tag ignored, then two channels on one tag: channel 1 wins
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b001, {10'd0, 5'd30}, {64'd0, 32'hEE}, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 3'b110, {5'd21, 5'd21, 5'd0}, {32'h66, 32'h55, 32'd0}, 0, 0, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 11, 32'h55, 2, 1);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        foreach (vecs[n]) begin
            @(negedge clk);
            idle();
            if (vecs[n].dv) disp(vecs[n].dtag, vecs[n].qjv, vecs[n].qj, vecs[n].vj, vecs[n].vk);
            bus.disp_qk_valid = vecs[n].qkv;
            bus.disp_qk       = vecs[n].qk;
            bus.cdb_valid     = vecs[n].cv;
            bus.cdb_tag       = vecs[n].ct;
            bus.cdb_value     = vecs[n].cval;
            bus.iss_ready     = vecs[n].ir;
            #1;
            chk($sformatf("v%0d.iss_valid", n), bus.iss_valid, vecs[n].e_iv);
            chk($sformatf("v%0d.iss_tag", n), bus.iss_tag, vecs[n].e_tag);
            chk($sformatf("v%0d.iss_vj", n), bus.iss_vj, vecs[n].e_vj);
            chk($sformatf("v%0d.iss_vk", n), bus.iss_vk, vecs[n].e_vk);
            chk($sformatf("v%0d.iss_pc", n), bus.iss_pc,
                vecs[n].e_iv ? 32'h1000 + 32'(vecs[n].e_tag) * 4 : 32'd0);
            chk($sformatf("v%0d.iss_op", n), bus.iss_op,
                vecs[n].e_iv ? OP_W'(vecs[n].e_tag) + 6'd1 : 6'd0);
            chk($sformatf("v%0d.count", n), bus.count, vecs[n].e_cnt);
        end

        // Fill the station with pending entries tag i waiting on tag 16+i.
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            idle();
            disp(5'(i), 1, 5'(16 + i), 0, 0);
        end
        @(negedge clk);
        idle();
        disp(20, 0, 0, 0, 0);
        #1;
        chk("fill.full", bus.full, 1);
        chk("fill.disp_ready", bus.disp_ready, 0);
        chk("fill.count", bus.count, 16);
        chk("fill.iss_valid", bus.iss_valid, 0);
        @(negedge clk);
        idle();
        bcast(0, 16, 32'h40);
        #1;
        chk("fill.rejected_count", bus.count, 16);
        @(negedge clk);
        idle();
        bus.iss_ready = 1'b1;
        disp(25, 0, 0, 32'h77, 0);
        #1;
        chk("fill.iss_valid_w", bus.iss_valid, 1);
        chk("fill.iss_tag_w", bus.iss_tag, 0);
        chk("fill.iss_vj_w", bus.iss_vj, 32'h40);
        chk("fill.no_reuse_ready", bus.disp_ready, 0);
        @(negedge clk);
        idle();
        disp(25, 0, 0, 32'h77, 0);
        bcast(2, 17, 32'h41);
        #1;
        chk("reuse.count", bus.count, 15);
        chk("reuse.full", bus.full, 0);
        chk("reuse.disp_ready", bus.disp_ready, 1);
        chk("reuse.iss_valid", bus.iss_valid, 0);
        @(negedge clk);
        idle();
        bus.iss_ready = 1'b1;
        #1;
        chk("reuse.count16", bus.count, 16);
        chk("reuse.oldest_tag", bus.iss_tag, 1);
        chk("reuse.oldest_vj", bus.iss_vj, 32'h41);
        @(negedge clk);
        idle();
        bus.iss_ready = 1'b1;
        #1;
        chk("reuse.young_tag", bus.iss_tag, 25);
        chk("reuse.young_vj", bus.iss_vj, 32'h77);
        chk("reuse.count15", bus.count, 15);

        // Flush the remaining pending entries.
        @(negedge clk);
        idle();
        bus.flush = 1'b1;
        #1;
        chk("flush1.iss_valid", bus.iss_valid, 0);
        chk("flush1.disp_ready", bus.disp_ready, 0);
        @(negedge clk);
        idle();
        #1;
        chk("flush1.count", bus.count, 0);
        chk("flush1.empty", bus.empty, 1);

        // Five ready entries, then flush with dispatch and issue requested.
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            idle();
            disp(5'(i), 0, 0, 32'(i), 0);
        end
        @(negedge clk);
        idle();
        bus.flush = 1'b1;
        bus.iss_ready = 1'b1;
        disp(9, 0, 0, 0, 0);
        #1;
        chk("flush2.pre_count", bus.count, 5);
        chk("flush2.iss_valid", bus.iss_valid, 0);
        chk("flush2.disp_ready", bus.disp_ready, 0);
        @(negedge clk);
        idle();
        #1;
        chk("flush2.count", bus.count, 0);
        chk("flush2.empty", bus.empty, 1);
        chk("flush2.iss_valid_after", bus.iss_valid, 0);

        // rdy low freezes state: broadcast and dispatch are both lost.
        @(negedge clk);
        idle();
        disp(7, 1, 8, 0, 32'h5);
        @(negedge clk);
        idle();
        bus.rdy = 1'b0;
        bcast(0, 8, 32'h99);
        disp(13, 0, 0, 0, 0);
        #1;
        chk("stall.disp_ready", bus.disp_ready, 0);
        chk("stall.iss_valid", bus.iss_valid, 0);
        @(negedge clk);
        idle();
        #1;
        chk("stall.count", bus.count, 1);
        chk("stall.not_woken", bus.iss_valid, 0);
        @(negedge clk);
        idle();
        bcast(0, 8, 32'hBB);
        @(negedge clk);
        idle();
        bus.iss_ready = 1'b1;
        #1;
        chk("stall.iss_valid_w", bus.iss_valid, 1);
        chk("stall.iss_tag", bus.iss_tag, 7);
        chk("stall.iss_vj", bus.iss_vj, 32'hBB);
        @(negedge clk);
        idle();
        #1;
        chk("stall.final_count", bus.count, 0);
        chk("stall.final_empty", bus.empty, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/rs_station.md
Name: rs_station

Overview:
- Parametrised out-of-order reservation station. Sits between the dispatch/rename stage and one execute unit.
- Holds up to DEPTH waiting instructions and captures source operands from CDB_N result-broadcast channels (ROB commit, ALU, load buffer).
- Each cycle, issues the oldest entry whose operands are both ready, using a valid/ready handshake.
- Operand tags use explicit valid bits, not a sentinel value.

Parameters:
- DEPTH, 16, number of entries (power of two, ≥2)
- XLEN, 32, operand/PC/immediate width
- TAG_W, 5, ROB tag width
- OP_W, 6, decoded opcode width
- CDB_N, 3, number of broadcast (wakeup) channels

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- rdy  in  1  global enable; low freezes all state
- flush  in  1  mispredict flush; empties the station
- disp_valid  in  1  dispatch request
- disp_ready  out  1  station can accept a dispatch this cycle
- disp_op  in  OP_W  opcode
- disp_pc  in  XLEN  instruction PC
- disp_imm  in  XLEN  immediate
- disp_tag  in  TAG_W  destination ROB tag
- disp_vj / disp_vk  in  XLEN  operand values, used when the matching q*_valid is 0
- disp_qj_valid / disp_qk_valid  in  1  operand pending
- disp_qj / disp_qk  in  TAG_W  producer tag of a pending operand
- cdb_valid  in  CDB_N  per-channel broadcast valid
- cdb_tag  in  CDB_N*TAG_W  channel c at bits [c*TAG_W +: TAG_W]
- cdb_value  in  CDB_N*XLEN  channel c at bits [c*XLEN +: XLEN]
- iss_valid  out  1  issue request to EX
- iss_ready  in  1  EX accepts
- iss_op, iss_pc, iss_imm, iss_tag, iss_vj, iss_vk  out  OP_W/XLEN/XLEN/TAG_W/XLEN/XLEN  issued entry fields
- count  out  $clog2(DEPTH)+1  occupied entries
- full, empty  out  1  count==DEPTH, count==0

Behaviour:
- Priority: rst > ~rdy > flush > normal operation.
- Reset: all entries invalid, qj/qk_valid cleared, age state cleared, count=0. Outputs after reset: empty=1, full=0, disp_ready=1, iss_valid=0, all iss_* data = 0.
- rdy=0:
  - No state change.
  - disp_ready=0 and iss_valid=0; a handshake cannot complete.
- flush (rdy=1):
  - All entries invalidated; count=0 next cycle.
  - A dispatch or issue presented in the same cycle is discarded.
  - disp_ready and iss_valid are forced 0 during the flush cycle.
- Dispatch:
  - disp_ready = rdy & ~flush & ~full. A slot freed by an issue in the same cycle does not raise disp_ready (no same-cycle reuse).
  - On disp_valid & disp_ready, write into the lowest-index free entry.
  - The new entry becomes the youngest in age order.
- Dispatch bypass: if disp_qj_valid and any cdb_valid[c] has cdb_tag[c]==disp_qj in the same cycle, store qj_valid=0 and vj=cdb_value[c]. Same rule for k.
- Wakeup:
  - For every valid entry with qj_valid and a channel tag match, next cycle qj_valid=0 and vj takes that channel's value. Same rule for k.
  - If several channels match one tag, the lowest channel index wins.
- Issue selection (combinational, from registered state only):
  - Candidate = valid & ~qj_valid & ~qk_valid.
  - iss_valid=1 when any candidate exists; the oldest candidate by dispatch order is selected.
  - When iss_valid=0, all iss_* data outputs = 0.
  - An entry dispatched or woken in cycle N is first eligible in cycle N+1. Minimum dispatch-to-issue latency is 1 cycle.
- Issue completion:
  - On iss_valid & iss_ready the selected entry is invalidated next cycle.
  - Without iss_ready, the selection may change only if an older entry becomes ready.
- count: +1 on accepted dispatch, −1 on accepted issue; both in the same cycle leaves count unchanged. Never exceeds DEPTH and never underflows.
- Age ordering:
  - Kept per entry, e.g. an age matrix.
  - Freed slots reused out of order must not disturb the oldest-first rule.
  - Entries dispatched in different cycles never tie.
- A wakeup whose tag matches no pending operand is ignored.
- Broadcasts to free entries are ignored.

Test Plan:
1. Reset, then dispatch 1 entry (qj_valid=qk_valid=0, vj=5, vk=7, tag=3) at cycle 0 -> iss_valid=1 with iss_tag=3, iss_vj=5, iss_vk=7 at cycle 1; count back to 0 after iss_ready.
2. Dispatch tag=4 with qj_valid=1, qj=9; broadcast cdb channel 1 tag=9 value=0x1234 two cycles later -> iss_vj=0x1234, iss_valid rises the cycle after the broadcast.
3. Dispatch with qk=2 while channel 0 broadcasts tag=2 value=0xAA in the same cycle -> entry issues next cycle with iss_vk=0xAA (bypass).
4. Fill DEPTH=16 entries, all pending -> full=1, disp_ready=0. Further disp_valid is ignored and count stays 16. Issue one entry together with disp_valid in the same cycle -> dispatch is not accepted; it is accepted next cycle.
5. Dispatch tags 10, 11, 12 pending. Wake 12 then 10 in the same cycle; hold iss_ready=0 one cycle, then 1 -> tag 10 issues first, then 12; tag 11 stays.
6. Occupy 5 entries, assert flush with disp_valid=1 -> count=0, empty=1, iss_valid=0 next cycle. Toggle rdy=0 during a broadcast -> no operand captured.
